fib_step_arbiter: RTL and testbench
===================================

# fib_step_arbiter

Shares one Fibonacci step engine (8-bit pair state, `(a,b) <- (b, a+b)`) among N requesters, each owning its own `(a,b)` context. A round-robin arbiter grants at most one requester per cycle. The granted context advances one step, and the emitted term comes out on a registered result port one cycle later. The block sits between N sequence consumers and the shared step datapath, replacing N copies of the single-stream generator.

## Interface
- `N`, default 4: number of requesters (2..16).
- `W`, default 8: term width; all arithmetic is modulo 2^W.
- `clk`  in  1  — sole clock, rising edge.
- `rst`  in  1  — asynchronous, active-low reset. Assert low: immediate reset. Deassertion is synchronised externally.
- `req`  in  N  — `req[i]` high requests one step of context i this cycle.
- `clr`  in  N  — `clr[i]` high reinitialises context i to `(a,b)=(0,1)`.
- `gnt`  out  N  — combinational one-hot (or zero) grant. A step transfers for i when `req[i] && gnt[i]`.
- `out_valid`  out  1  — registered; high one cycle after each transfer.
- `out_id`  out  clog2(N)  — registered index of the stepped context.
- `out_data`  out  W  — registered term emitted, i.e. the old `a` of that context.

## Operation
- **State:**
  - Per context i: `a[i]`, `b[i]`, each W bits.
  - Round-robin pointer `ptr` (clog2(N) bits).
  - Output registers.
- **Reset values (rst low):**
  - every `a[i]=0`, every `b[i]=1`;
  - `ptr=0`;
  - `out_valid=0`, `out_id=0`, `out_data=0`.
- **Eligibility:** `elig[i] = req[i] && !clr[i]`. Clear has priority; a requester clearing this cycle is never granted.
- **Arbitration (combinational):**
  - `gnt` = first eligible index scanning `ptr, ptr+1, …, ptr+N-1` (mod N).
  - `gnt=0` if nothing is eligible.
- **On a transfer to k at a clock edge:**
  - `a[k] <= b[k]`, `b[k] <= a[k]+b[k]` (mod 2^W, carry discarded);
  - `out_data <= a[k]`, `out_id <= k`, `out_valid <= 1`;
  - `ptr <= (k+1) mod N`.
- **No transfer:** `out_valid <= 0`; `out_id` and `out_data` hold; `ptr` holds.
- **Clear:** `clr[i]` sets `a[i]=0`, `b[i]=1` at the edge. Multiple clears in one cycle are all applied. A clear of context j never blocks a grant to k≠j in the same cycle.
- **Emitted sequence per context from reset/clear:** 0,1,1,2,3,5,8,13,…, wrapping modulo 2^W.
- **req semantics:** level. A requester holding `req` high receives a step on every granted cycle. The consumer drops `req` in the cycle it sees `gnt` if it wants exactly one step.
- Contexts are fully independent; stepping one never alters another.

## Timing
- **Grant latency:** 0 cycles. `gnt` depends combinationally on `req`, `clr`, `ptr`.
- **Result latency:** 1 cycle. The transfer in cycle t gives `out_valid`/`out_id`/`out_data` in cycle t+1.
- **Throughput:** one step per cycle aggregate. With all N requesting continuously, each requester is served once every N cycles.
- **Fairness:** a continuously requesting, non-clearing requester is granted within N cycles.
- **Back-to-back:** consecutive transfers may target the same context only when it is the sole eligible requester.
- **Async reset mid-operation:**
  - All state and outputs go to their reset values immediately, without waiting for a clock edge.
  - `gnt` follows combinationally from `ptr=0`.
  - No partial step is retained.
- No combinational path from `req`/`clr` to `out_*`.

## Test plan
- **Single stream:** after reset, hold `req[0]=1` for 8 cycles → `gnt[0]` high each cycle; `out_data` = 0,1,1,2,3,5,8,13 with `out_id=0`, each one cycle after its grant.
- **Wrap:** step context 1 seventeen times → `out_data` tail …,144,233,121,98,219 (mod 256).
- **Round robin:** all `req` high for 8 cycles from reset → `gnt` = 0001,0010,0100,1000,0001,…; `out_id` = 0,1,2,3,0,1,2,3; `out_data` = 0,0,0,0,1,1,1,1.
- **Pointer skip:** after a grant to 0, `req=4'b1010` held → grants 1,3,1,3.
- **Clear collision:**
  - Advance context 2 to term 5.
  - Assert `clr[2]` and `req[2]` together → `gnt[2]=0` that cycle; another eligible requester may be granted instead.
  - Next grant to 2 → `out_data=0`, then 1.
- **Reset mid-run:**
  - While `out_valid=1`, pull `rst` low between edges → `out_valid`, `out_id`, `out_data` read 0 immediately.
  - After release, `req[3]` → `out_data=0`, `out_id=3`.

Source files
------------

// File: rtl/fib_step_arbiter.sv
// Shared Fibonacci step engine: round-robin arbitration of N per-requester (a,b)
// contexts onto one step datapath, with a registered result port.
module fib_step_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8,
  localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   clr,
  output logic [N-1:0]   gnt,
  output logic           out_valid,
  output logic [IDW-1:0] out_id,
  output logic [W-1:0]   out_data
);

  logic [W-1:0]   a_q [N];
  logic [W-1:0]   b_q [N];
  logic [IDW-1:0] ptr;

  logic [N-1:0]   elig;
  logic           xfer;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] ptr_next;
  int unsigned    scan_idx;

  // A clearing requester is never eligible, so clear and step never collide.
  assign elig = req & ~clr;

  // Scan from ptr upward (mod N); the first eligible index wins.
  always_comb begin
    gnt      = '0;
    xfer     = 1'b0;
    gnt_idx  = '0;
    scan_idx = 0;
    for (int unsigned off = 0; off < N; off++) begin
      scan_idx = 32'(ptr) + off;
      if (scan_idx >= N) begin
        scan_idx = scan_idx - N;
      end
      if (!xfer && elig[IDW'(scan_idx)]) begin
        xfer                 = 1'b1;
        gnt_idx              = IDW'(scan_idx);
        gnt[IDW'(scan_idx)]  = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_next = ptr;
    if (xfer) begin
      if (gnt_idx == IDW'(N - 1)) begin
        ptr_next = '0;
      end else begin
        ptr_next = gnt_idx + IDW'(1);
      end
    end
  end

  // Per-context state: clear wins; otherwise advance only the granted context.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(N); i++) begin
        a_q[i] <= '0;
        b_q[i] <= W'(1);
      end
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        if (clr[i]) begin
          a_q[i] <= '0;
          b_q[i] <= W'(1);
        end else if (xfer && (gnt_idx == IDW'(i))) begin
          a_q[i] <= b_q[i];
          b_q[i] <= a_q[i] + b_q[i];
        end
      end
    end
  end

  // Pointer and result registers; id/data hold when nothing transfers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr       <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
      out_data  <= '0;
    end else begin
      ptr       <= ptr_next;
      out_valid <= xfer;
      if (xfer) begin
        out_id   <= gnt_idx;
        out_data <= a_q[gnt_idx];
      end
    end
  end

endmodule

// File: tb/tb_fib_step_arbiter.sv
// Directed bench for fib_step_arbiter (N=4, W=8) with hand-computed expectations.
module tb_fib_step_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] clr;
  logic [3:0] gnt;
  logic       out_valid;
  logic [1:0] out_id;
  logic [7:0] out_data;

  int total;
  int bad;

  fib_step_arbiter #(.N(4), .W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .clr       (clr),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_id    (out_id),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check gnt, then check the registered result.
  task automatic step(input string tag, input logic [3:0] r, input logic [3:0] c,
                      input logic [3:0] egnt, input logic evalid,
                      input logic [1:0] eid, input logic [7:0] edata);
    @(negedge clk);
    req = r;
    clr = c;
    #1;
    chk({tag, ".gnt"}, 32'(gnt), 32'(egnt));
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, 32'(out_valid), 32'(evalid));
    chk({tag, ".id"}, 32'(out_id), 32'(eid));
    chk({tag, ".data"}, 32'(out_data), 32'(edata));
  endtask

  // Async reset between edges: outputs clear at once, gnt follows ptr=0.
  task automatic mid_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk({tag, ".valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".id"}, 32'(out_id), 32'd0);
    chk({tag, ".data"}, 32'(out_data), 32'd0);
    req = 4'b1111;
    clr = 4'b0000;
    #1;
    chk({tag, ".gnt"}, 32'(gnt), 32'b0001);
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [7:0] wrap_seq [17];
  logic [7:0] fib8 [8];
  logic [3:0] rr_gnt [4];

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    req   = 4'b0000;
    clr   = 4'b0000;
    fib8     = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13};
    wrap_seq = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34,
                 8'd55, 8'd89, 8'd144, 8'd233, 8'd121, 8'd98, 8'd219};
    rr_gnt   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    #12;
    chk("reset.valid", 32'(out_valid), 32'd0);
    chk("reset.id", 32'(out_id), 32'd0);
    chk("reset.data", 32'(out_data), 32'd0);
    chk("reset.gnt_idle", 32'(gnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++)
      step($sformatf("single%0d", i), 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, fib8[i]);

    step("idle", 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'd13);

    for (int i = 0; i < 17; i++)
      step($sformatf("wrap%0d", i), 4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1, wrap_seq[i]);

    mid_reset("rst_mid1");

    for (int i = 0; i < 8; i++)
      step($sformatf("rr%0d", i), 4'b1111, 4'b0000, rr_gnt[i % 4], 1'b1,
           2'(i % 4), (i < 4) ? 8'd0 : 8'd1);

    step("skip_g0", 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, 8'd1);
    step("skip0", 4'b1010, 4'b0000, 4'b0010, 1'b1, 2'd1, 8'd1);
    step("skip1", 4'b1010, 4'b0000, 4'b1000, 1'b1, 2'd3, 8'd1);
    step("skip2", 4'b1010, 4'b0000, 4'b0010, 1'b1, 2'd1, 8'd2);
    step("skip3", 4'b1010, 4'b0000, 4'b1000, 1'b1, 2'd3, 8'd2);

    step("adv0", 4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, 8'd1);
    step("adv1", 4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, 8'd2);
    step("adv2", 4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, 8'd3);
    step("adv3", 4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, 8'd5);
    step("collide", 4'b0101, 4'b0100, 4'b0001, 1'b1, 2'd0, 8'd2);
    step("post_clr0", 4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, 8'd0);
    step("post_clr1", 4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, 8'd1);
    step("clr_only", 4'b0100, 4'b0100, 4'b0000, 1'b0, 2'd2, 8'd1);
    step("clr_only_after", 4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, 8'd0);

    mid_reset("rst_mid2");
    step("after_rst0", 4'b1000, 4'b0000, 4'b1000, 1'b1, 2'd3, 8'd0);
    step("after_rst1", 4'b1000, 4'b0000, 4'b1000, 1'b1, 2'd3, 8'd1);
    step("ctx0_fresh", 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
